// File: rtl/recursion_pkg.sv
// Shared types and helpers for the recursion bank.
// Contents: stage_ctl_t (pipeline valid + channel tag), round_bias() for
// round-half-up, sat_trunc() for reducing a wide result to a sample width,
// ch_in_range() for channel index checks.
// Macro RECURSION_BANK_SAT_EN selects saturation (defined) or wrap (undefined)
// inside sat_trunc().
package recursion_pkg;

  localparam int unsigned CH_FIELD_W = 8;
  localparam int unsigned CALC_W     = 64;

  typedef struct packed {
    logic                  valid;
    logic [CH_FIELD_W-1:0] ch;
  } stage_ctl_t;

  // Half an LSB of the rounded result: 2^(frac-1).
  function automatic logic [CALC_W-1:0] round_bias(input int unsigned frac);
    return CALC_W'(1) << (frac - 1);
  endfunction

  // Reduce a wide signed value to 'width' bits, result sign-extended to CALC_W.
  function automatic logic signed [CALC_W-1:0] sat_trunc(
    input logic signed [CALC_W-1:0] value,
    input int unsigned              width
  );
`ifdef RECURSION_BANK_SAT_EN
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (CALC_W'(1) <<< (width - 1)) - CALC_W'(1);
    lo = ~hi;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
`else
    return (value <<< (CALC_W - width)) >>> (CALC_W - width);
`endif
  endfunction

  function automatic logic ch_in_range(input int unsigned ch, input int unsigned n);
    return ch < n;
  endfunction

endpackage

// File: rtl/cmult_pipe.sv
// One-stage pipelined complex multiplier: registers the four partial
// products of (sr + j si) * (ar + j ai) when en is high.
// Ports: clk, rst (async active-low), en, sr/si (DATA_W signed),
//        ar/ai (COEF_W signed), p_rr = sr*ar, p_ii = si*ai,
//        p_ri = sr*ai, p_ir = si*ar (DATA_W+COEF_W signed, registered).
module cmult_pipe
  import recursion_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned COEF_W = 18
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic signed [DATA_W-1:0]         sr,
  input  logic signed [DATA_W-1:0]         si,
  input  logic signed [COEF_W-1:0]         ar,
  input  logic signed [COEF_W-1:0]         ai,
  output logic signed [DATA_W+COEF_W-1:0]  p_rr,
  output logic signed [DATA_W+COEF_W-1:0]  p_ii,
  output logic signed [DATA_W+COEF_W-1:0]  p_ri,
  output logic signed [DATA_W+COEF_W-1:0]  p_ir
);

  localparam int unsigned PW = DATA_W + COEF_W;

  // Partial product registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else if (en) begin
      p_rr <= PW'(sr) * PW'(ar);
      p_ii <= PW'(si) * PW'(ai);
      p_ri <= PW'(sr) * PW'(ai);
      p_ir <= PW'(si) * PW'(ar);
    end
  end

endmodule

// File: rtl/recursion_bank.sv
// Time-multiplexed bank of CHANNELS complex first-order recursions
// y[n] = a*y[n-1] + x[n], sharing one pipelined complex multiplier.
// Ports: clk, rst (async active-low); in_valid/in_ready/in_ch/in_r/in_i
//        input beat; coef_we/coef_ch/coef_r/coef_i coefficient write;
//        init_en/init_ch/init_r/init_i state write; out_valid/out_ready/
//        out_ch/out_r/out_i output beat.
// Pipeline: S1 operand capture, S2 products (cmult_pipe), S3 output register
// with state writeback. Macro RECURSION_BANK_SAT_EN: saturate instead of wrap.
module recursion_bank
  import recursion_pkg::*;
#(
  parameter  int unsigned CHANNELS  = 4,
  parameter  int unsigned DATA_W    = 24,
  parameter  int unsigned COEF_W    = 18,
  parameter  int unsigned COEF_FRAC = 16,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_i,
  input  logic              coef_we,
  input  logic [CH_W-1:0]   coef_ch,
  input  logic [COEF_W-1:0] coef_r,
  input  logic [COEF_W-1:0] coef_i,
  input  logic              init_en,
  input  logic [CH_W-1:0]   init_ch,
  input  logic [DATA_W-1:0] init_r,
  input  logic [DATA_W-1:0] init_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_i
);

  localparam int unsigned PW    = DATA_W + COEF_W;
  localparam int unsigned SUM_W = PW + 2;
  localparam logic signed [SUM_W-1:0] RND_BIAS = SUM_W'(round_bias(COEF_FRAC));

  logic signed [DATA_W-1:0] st_r [CHANNELS];
  logic signed [DATA_W-1:0] st_i [CHANNELS];
  logic signed [COEF_W-1:0] cf_r [CHANNELS];
  logic signed [COEF_W-1:0] cf_i [CHANNELS];

  stage_ctl_t               s1_ctl, s2_ctl;
  logic signed [DATA_W-1:0] s1_xr, s1_xi, s1_sr, s1_si, s2_xr, s2_xi;
  logic signed [COEF_W-1:0] s1_ar, s1_ai;
  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;

  logic                     started;
  logic                     adv, hazard, accept, wb;
  logic [CH_FIELD_W-1:0]    in_ch_f;
  logic signed [DATA_W-1:0] rd_sr, rd_si;
  logic signed [COEF_W-1:0] rd_ar, rd_ai;
  logic signed [SUM_W-1:0]  pr_full, pi_full, pr_rnd, pi_rnd, sum_r, sum_i;
  logic signed [DATA_W-1:0] res_r, res_i;

  // Handshake: a channel may not re-enter while it is still in S1 or S2,
  // so its state read always sees the previous writeback.
  always_comb begin
    in_ch_f  = CH_FIELD_W'(in_ch);
    adv      = !out_valid || out_ready;
    hazard   = (s1_ctl.valid && (s1_ctl.ch == in_ch_f)) ||
               (s2_ctl.valid && (s2_ctl.ch == in_ch_f));
    in_ready = started && adv && !hazard;
    accept   = in_valid && in_ready;
    wb       = adv && s2_ctl.valid;
  end

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) started <= 1'b0;
    else      started <= 1'b1;
  end

  // Combinational per-channel read for S1 capture.
  always_comb begin
    rd_sr = '0;
    rd_si = '0;
    rd_ar = '0;
    rd_ai = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_ch == CH_W'(c)) begin
        rd_sr = st_r[c];
        rd_si = st_i[c];
        rd_ar = cf_r[c];
        rd_ai = cf_i[c];
      end
    end
  end

  // S1: operand capture; out-of-range channels become bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_ctl <= '0;
      s1_xr  <= '0;
      s1_xi  <= '0;
      s1_sr  <= '0;
      s1_si  <= '0;
      s1_ar  <= '0;
      s1_ai  <= '0;
    end else if (adv) begin
      s1_ctl.valid <= accept && ch_in_range(32'(in_ch), CHANNELS);
      s1_ctl.ch    <= in_ch_f;
      s1_xr        <= $signed(in_r);
      s1_xi        <= $signed(in_i);
      s1_sr        <= rd_sr;
      s1_si        <= rd_si;
      s1_ar        <= rd_ar;
      s1_ai        <= rd_ai;
    end
  end

  cmult_pipe #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_cmult (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .sr   (s1_sr),
    .si   (s1_si),
    .ar   (s1_ar),
    .ai   (s1_ai),
    .p_rr (p_rr),
    .p_ii (p_ii),
    .p_ri (p_ri),
    .p_ir (p_ir)
  );

  // S2: control and x travel alongside the products.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_ctl <= '0;
      s2_xr  <= '0;
      s2_xi  <= '0;
    end else if (adv) begin
      s2_ctl <= s1_ctl;
      s2_xr  <= s1_xr;
      s2_xi  <= s1_xi;
    end
  end

  // S3 arithmetic: combine products, round half-up, add x, reduce width.
  always_comb begin
    pr_full = SUM_W'(p_rr) - SUM_W'(p_ii);
    pi_full = SUM_W'(p_ri) + SUM_W'(p_ir);
    pr_rnd  = (pr_full + RND_BIAS) >>> COEF_FRAC;
    pi_rnd  = (pi_full + RND_BIAS) >>> COEF_FRAC;
    sum_r   = pr_rnd + SUM_W'(s2_xr);
    sum_i   = pi_rnd + SUM_W'(s2_xi);
    res_r   = DATA_W'(sat_trunc(CALC_W'(sum_r), DATA_W));
    res_i   = DATA_W'(sat_trunc(CALC_W'(sum_i), DATA_W));
  end

  // S3 output register; data held while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_r     <= '0;
      out_i     <= '0;
    end else if (adv) begin
      out_valid <= s2_ctl.valid;
      if (s2_ctl.valid) begin
        out_ch <= CH_W'(s2_ctl.ch);
        out_r  <= res_r;
        out_i  <= res_i;
      end
    end
  end

  // State storage: init_en takes priority over a colliding writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        st_r[c] <= '0;
        st_i[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (init_en && (init_ch == CH_W'(c))) begin
          st_r[c] <= $signed(init_r);
          st_i[c] <= $signed(init_i);
        end else if (wb && (s2_ctl.ch == CH_FIELD_W'(c))) begin
          st_r[c] <= res_r;
          st_i[c] <= res_i;
        end
      end
    end
  end

  // Coefficient storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cf_r[c] <= '0;
        cf_i[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (coef_we && (coef_ch == CH_W'(c))) begin
          cf_r[c] <= $signed(coef_r);
          cf_i[c] <= $signed(coef_i);
        end
      end
    end
  end

endmodule

// File: doc/recursion_bank.md
# recursion_bank

Time-multiplexed bank of `CHANNELS` independent complex first-order recursions, y_c[n] = a_c·y_c[n−1] + x_c[n], in signed fixed point. Coefficients and state are held per channel and are writable at run time. It replaces one-module-per-recursion instances in the lookahead/lookback filter paths: a single pipelined complex multiplier is shared across channels. Input and output use valid/ready handshakes, so it slots between the sample front-end and the FIR accumulation stage.

## Interface
- `CHANNELS`, 4: number of recursions, ≥1; `CH_W = $clog2(CHANNELS)` (min 1) is derived.
- `DATA_W`, 24: width of sample/state real and imaginary parts, signed.
- `COEF_W`, 18: width of coefficient real and imaginary parts, signed.
- `COEF_FRAC`, 16: fractional bits of the coefficient, 1 ≤ `COEF_FRAC` < `COEF_W`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` / `in_ready` in/out 1: input handshake.
- `in_ch` in `CH_W`: channel of the input beat.
- `in_r`, `in_i` in `DATA_W`: x[n].
- `coef_we` in 1: write coefficient `coef_r`/`coef_i` (`COEF_W` each) to channel `coef_ch` (`CH_W`).
- `init_en` in 1: write state `init_r`/`init_i` (`DATA_W` each) to channel `init_ch` (`CH_W`).
- `out_valid` / `out_ready` out/in 1: output handshake.
- `out_ch` out `CH_W`: channel of the output beat.
- `out_r`, `out_i` out `DATA_W`: y[n].

## Operation
- A beat is accepted on a rising edge with `in_valid && in_ready`.
- Pipeline stages:
  - S1: registers ch, x, state[ch], coef[ch].
  - S2: registers the four partial products sr·ar, si·ai, sr·ai, si·ar, each `DATA_W+COEF_W` bits.
  - S3 (output register): computes pr = sr·ar − si·ai and pi = sr·ai + si·ar.
- Rounding and sum:
  - Round half-up: add 2^(`COEF_FRAC`−1), then arithmetic shift right by `COEF_FRAC`.
  - Add x at full width, then reduce to `DATA_W` (see Configuration).
  - The result is written to state[ch] and to `out_*` on the same edge.
- `adv = !out_valid || out_ready`. When `adv` is 0, all stages hold.
- Hazard: `in_ready = adv && !(S1.valid && S1.ch==in_ch) && !(S2.valid && S2.ch==in_ch)`.
- Bubbles propagate as `valid = 0`. No beat is ever dropped or duplicated.
- Coefficient writes:
  - `coef_we` updates the coefficient on the edge.
  - A beat that is already in S1 uses the coefficient it captured.
- State writes via `init_en`:
  - `init_en` overrides the state.
  - If it coincides with the S3 writeback to the same channel, `init_*` wins. The output beat still carries the computed value.
  - A beat for that channel already in flight still completes, but its writeback is suppressed only on that exact collision edge.
- `init_en` and `coef_we` are accepted regardless of handshake state.
- `in_ch`, `coef_ch` or `init_ch` ≥ `CHANNELS`: input beat is accepted and discarded (no output); writes are ignored.

## Timing
- Latency: a beat accepted at edge k appears with `out_valid = 1` after edge k+2, if `adv` stays 1.
- Throughput:
  - One beat per cycle when consecutive beats use distinct channels and `out_ready = 1`.
  - The same channel is accepted at most once every 3 cycles.
- Reset values:
  - `out_valid`, `out_ch`, `out_r`, `out_i` = 0.
  - `in_ready` = 1 one cycle after reset deassert; 0 while `rst` = 0.
  - All states, coefficients and stage valids = 0.
- Reset asserted mid-operation: in-flight beats are discarded; nothing is emitted after deassertion.
- `out_*` are held stable while `out_valid && !out_ready`.

## Configuration
- `RECURSION_BANK_SAT_EN`:
  - Defined: the S3 result saturates to [−2^(`DATA_W`−1), 2^(`DATA_W`−1)−1], per component, before writeback and output.
  - Undefined: the result is truncated to `DATA_W` LSBs (two's-complement wrap).
- Rounding is identical in both builds.

## Structure
- Package `recursion_pkg` holds:
  - rounding-offset constant function `round_bias(frac)`;
  - `sat_trunc(value, width)` function, guarded by the macro;
  - typedef `stage_ctl_t` (valid, ch).
- Sub-module `cmult_pipe`: one-stage complex multiplier (four registered products with enable). The bank instantiates it once for S1→S2.
- State and coefficient storage are flop arrays in the top level (no RAM inference; the combinational read in S1 needs it).

## Test plan
- Settling, ch0: coef (32768, 0) = 0.5, state init 0, x = (1000, 0) ×4 → out_r 1000, 1500, 1750, 1875; out_i 0; each 2 cycles after its accept.
- Rotation, ch1: coef (0, 65536) = j, init (100, 0), x = 0 ×4 → (0, 100), (−100, 0), (0, −100), (100, 0).
- Hazard and full rate:
  - `in_ch` = 2, 2 on consecutive cycles → `in_ready` low for exactly 2 cycles before the second beat is accepted.
  - Round-robin ch 0..3 → a beat accepted every cycle.
- Backpressure: `out_ready` = 0 for 5 cycles with 3 beats in flight → `out_*` held, `in_ready` = 0; all 3 beats delivered in order after release.
- Saturation: coef (65536, 0), x = (2^22, 0) repeated.
  - With `RECURSION_BANK_SAT_EN`: 4194304 then 8388607 held.
  - Without: second output −8388608.
- Reset and collision:
  - `rst` pulsed low with 2 beats in flight → no outputs afterwards, states 0.
  - `init_en` to ch3 on its writeback edge → next ch3 result uses `init_*`.
